ysyx_idu: RTL

YSYX_IDU -- requirements
Module: ysyx_idu

---
 rtl/ysyx_idu.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ysyx_idu.sv
// RV32I instruction decode stage: a single-entry valid/ready pipeline register
// that splits the fetched word into fields, immediate, write-enable and illegal flag.
module ysyx_idu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic [DATA_W-1:0] inst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              valid_o,
  input  logic              next_ready,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              wen_o,
  output logic              illegal_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] word;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;
  logic        dec_wen;
  logic        dec_illegal;
  logic        accept;

  assign word       = inst[31:0];
  assign dec_opcode = word[6:0];
  assign dec_funct3 = word[14:12];
  assign dec_rd     = word[11:7];

  assign ready_o = !valid_o || next_ready;
  assign accept  = prev_valid && ready_o && !flush;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    dec_imm     = '0;
    dec_wen     = 1'b0;
    dec_illegal = 1'b0;
    unique case (dec_opcode)
      OP_LUI, OP_AUIPC: begin
        dec_imm = {word[31:12], 12'b0};
        dec_wen = 1'b1;
      end
      OP_JAL: begin
        dec_imm = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
        dec_wen = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        dec_imm = {{20{word[31]}}, word[31:20]};
        dec_wen = 1'b1;
      end
      OP_SYSTEM: begin
        dec_imm = {{20{word[31]}}, word[31:20]};
        dec_wen = (dec_funct3 != 3'b000);
      end
      OP_BRANCH: dec_imm = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
      OP_STORE:  dec_imm = {{20{word[31]}}, word[31:25], word[11:7]};
      OP_OP:     dec_wen = 1'b1;
      OP_MISC:   ;
      default:   dec_illegal = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded, so never advertise them.
    if (dec_rd == 5'd0) dec_wen = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o   <= 1'b0;
      pc_o      <= '0;
      inst_o    <= '0;
      opcode_o  <= '0;
      funct3_o  <= '0;
      funct7_o  <= '0;
      rs1_o     <= '0;
      rs2_o     <= '0;
      rd_o      <= '0;
      imm_o     <= '0;
      wen_o     <= 1'b0;
      illegal_o <= 1'b0;
    end else if (flush) begin
      valid_o <= 1'b0;
    end else if (accept) begin
      valid_o   <= 1'b1;
      pc_o      <= pc;
      inst_o    <= inst;
      opcode_o  <= dec_opcode;
      funct3_o  <= dec_funct3;
      funct7_o  <= word[31:25];
      rs1_o     <= word[19:15];
      rs2_o     <= word[24:20];
      rd_o      <= dec_rd;
      imm_o     <= dec_illegal ? '0 : DATA_W'($signed(dec_imm));
      wen_o     <= dec_wen && !dec_illegal;
      illegal_o <= dec_illegal;
    end else if (next_ready) begin
      valid_o <= 1'b0;
    end
  end

endmodule
